end_screen_anim: RTL and testbench

//  Animated race-end screen for N players. Latches the first player to reach the finish (MAX_POS-1).

---
 rtl/end_screen_pkg.sv | 32 +++
 rtl/anim_tick_gen.sv | 35 +++
 rtl/end_screen_anim.sv | 196 +++++++++++++++++++
 tb/tb_end_screen_anim.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/end_screen_pkg.sv
// Shared types and constants for the race-end screen animation.
//   state_t  : animation FSM state encoding
//   PID_W    : width of a player index
//   PALETTE  : per-player colour mask, bit order {G,R,B}
package end_screen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_BLINK = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   localparam int unsigned PID_W = 3;

   // Colour mask bit positions inside a PALETTE entry
   localparam int unsigned PAL_G = 2;
   localparam int unsigned PAL_R = 1;
   localparam int unsigned PAL_B = 0;

   localparam logic [2:0] PALETTE [0:7] = '{
      3'b100,  // 0: green
      3'b010,  // 1: red
      3'b001,  // 2: blue
      3'b110,  // 3: green + red
      3'b101,  // 4: green + blue
      3'b011,  // 5: red + blue
      3'b111,  // 6: green + red + blue
      3'b010   // 7: red alone
   };

endpackage

// File: rtl/anim_tick_gen.sv
// Animation tick generator: a free-running 0..TICK_DIV-1 cycle counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : counter active; run=0 zeroes the counter
//   advance    : counter steps only while high, otherwise it holds its value
//   tick       : one-cycle pulse on the cycle the counter wraps
module anim_tick_gen #(
   parameter int unsigned TICK_DIV = 4096
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic advance,
   output logic tick
);

   localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] cnt_q;
   logic          at_wrap;

   assign at_wrap = (cnt_q == CW'(TICK_DIV - 1));
   assign tick    = run & advance & at_wrap;

   // Cycle counter; wraps to zero after TICK_DIV-1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (!run) begin
         cnt_q <= '0;
      end else if (advance) begin
         cnt_q <= at_wrap ? '0 : cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/end_screen_anim.sv
// Animated race-end screen. Latches the first player to reach the finish and plays
// sweep-fill, blink and steady-hold phases in that player's colour on the LED strip.
//   clk, rst_n          : clock, asynchronous active-low reset
//   enable              : screen selected; when low o_* = i_* and all state holds
//   clear               : synchronous restart to IDLE (priority over everything)
//   pos_bus             : packed player positions, player k at [k*PW +: PW]
//   led_number          : index of the LED currently being rendered
//   i_*_intensity       : upstream intensities (passed through when disabled)
//   o_*_intensity       : downstream intensities (combinational)
//   winner_valid        : a winner has been latched
//   winner_id           : latched winner index
module end_screen_anim
   import end_screen_pkg::*;
#(
   parameter int unsigned MAX_POS     = 109,
   parameter int unsigned N_PLAYERS   = 4,
   parameter logic [7:0]  PEAK        = 8'd5,
   parameter int unsigned TICK_DIV    = 4096,
   parameter int unsigned BLINK_TICKS = 16,
   parameter int unsigned BLINK_COUNT = 6,
   localparam int unsigned PW         = $clog2(MAX_POS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    clear,
   input  logic [N_PLAYERS*PW-1:0] pos_bus,
   input  logic [PW-1:0]           led_number,
   input  logic [7:0]              i_red_intensity,
   input  logic [7:0]              i_green_intensity,
   input  logic [7:0]              i_blue_intensity,
   output logic [7:0]              o_red_intensity,
   output logic [7:0]              o_green_intensity,
   output logic [7:0]              o_blue_intensity,
   output logic                    winner_valid,
   output logic [PID_W-1:0]        winner_id
);

   localparam int unsigned FW   = PW + 1;
   localparam int unsigned BC_W = $clog2(BLINK_COUNT + 1);
   localparam int unsigned BT_W = (BLINK_TICKS > 2) ? $clog2(BLINK_TICKS) : 1;

   state_t            state_q,  state_d;
   logic              valid_q,  valid_d;
   logic [PID_W-1:0]  wid_q,    wid_d;
   logic [FW-1:0]     fill_q,   fill_d;
   logic              blink_on_q, blink_on_d;
   logic [BC_W-1:0]   blink_cnt_q, blink_cnt_d;
   logic [BT_W-1:0]   half_cnt_q,  half_cnt_d;

   logic              tick;
   logic              run_c;
   logic              found_c;
   logic [PID_W-1:0]  found_idx_c;

   // Timer runs outside IDLE; clear zeroes it together with the FSM
   assign run_c = (state_q != ST_IDLE) && !clear;

   anim_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (run_c),
      .advance (enable),
      .tick    (tick)
   );

   // Finisher priority encoder; scanning downwards leaves the lowest index
   always_comb begin
      found_c     = 1'b0;
      found_idx_c = '0;
      for (int k = int'(N_PLAYERS) - 1; k >= 0; k--) begin
         if (pos_bus[k*PW +: PW] == PW'(MAX_POS - 1)) begin
            found_c     = 1'b1;
            found_idx_c = PID_W'(k);
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         valid_q     <= 1'b0;
         wid_q       <= '0;
         fill_q      <= '0;
         blink_on_q  <= 1'b0;
         blink_cnt_q <= '0;
         half_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         wid_q       <= wid_d;
         fill_q      <= fill_d;
         blink_on_q  <= blink_on_d;
         blink_cnt_q <= blink_cnt_d;
         half_cnt_q  <= half_cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      wid_d       = wid_q;
      fill_d      = fill_q;
      blink_on_d  = blink_on_q;
      blink_cnt_d = blink_cnt_q;
      half_cnt_d  = half_cnt_q;

      if (clear) begin
         state_d     = ST_IDLE;
         valid_d     = 1'b0;
         wid_d       = '0;
         fill_d      = '0;
         blink_on_d  = 1'b0;
         blink_cnt_d = '0;
         half_cnt_d  = '0;
      end else if (enable) begin
         unique case (state_q)
            ST_IDLE: begin
               if (found_c) begin
                  state_d = ST_SWEEP;
                  valid_d = 1'b1;
                  wid_d   = found_idx_c;
                  fill_d  = '0;
               end
            end
            ST_SWEEP: begin
               if (tick) begin
                  if (fill_q == FW'(MAX_POS)) begin
                     state_d     = ST_BLINK;
                     blink_on_d  = 1'b0;
                     blink_cnt_d = '0;
                     half_cnt_d  = '0;
                  end else begin
                     fill_d = fill_q + FW'(1);
                  end
               end
            end
            ST_BLINK: begin
               if (tick) begin
                  if (half_cnt_q == BT_W'(BLINK_TICKS - 1)) begin
                     half_cnt_d  = '0;
                     blink_on_d  = !blink_on_q;
                     blink_cnt_d = blink_cnt_q + BC_W'(1);
                     // Last toggle enters HOLD with the strip lit
                     if (blink_cnt_q == BC_W'(BLINK_COUNT - 1)) begin
                        state_d    = ST_HOLD;
                        blink_on_d = 1'b1;
                     end
                  end else begin
                     half_cnt_d = half_cnt_q + BT_W'(1);
                  end
               end
            end
            ST_HOLD: begin
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign winner_valid = valid_q;
   assign winner_id    = wid_q;

   // Render: decide whether the current LED is lit, then apply the winner's palette
   logic          in_range_c;
   logic          lit_c;
   logic [2:0]    pal_c;
   logic [7:0]    red_c, green_c, blue_c;

   always_comb begin
      in_range_c = {1'b0, led_number} < FW'(MAX_POS);
      lit_c      = 1'b0;
      unique case (state_q)
         ST_SWEEP: lit_c = ({1'b0, led_number} < fill_q);
         ST_BLINK: lit_c = blink_on_q;
         ST_HOLD:  lit_c = 1'b1;
         default:  lit_c = 1'b0;
      endcase
      lit_c   = lit_c && in_range_c;
      pal_c   = PALETTE[wid_q];
      red_c   = (lit_c && pal_c[PAL_R]) ? PEAK : 8'd0;
      green_c = (lit_c && pal_c[PAL_G]) ? PEAK : 8'd0;
      blue_c  = (lit_c && pal_c[PAL_B]) ? PEAK : 8'd0;
   end

   assign o_red_intensity   = enable ? red_c   : i_red_intensity;
   assign o_green_intensity = enable ? green_c : i_green_intensity;
   assign o_blue_intensity  = enable ? blue_c  : i_blue_intensity;

endmodule

// File: tb/tb_end_screen_anim.sv
// Directed bench for end_screen_anim with a short timebase (TICK_DIV=2, BLINK_TICKS=2,
// BLINK_COUNT=4). Inputs change and outputs are sampled around the falling edge.
module tb_end_screen_anim;

   localparam int unsigned MAX_POS = 109;
   localparam int unsigned NP      = 4;
   localparam int unsigned PW      = 7;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             enable;
   logic             clear;
   logic [NP*PW-1:0] pos_bus;
   logic [PW-1:0]    led_number;
   logic [7:0]       i_red, i_green, i_blue;
   logic [7:0]       o_red, o_green, o_blue;
   logic             winner_valid;
   logic [2:0]       winner_id;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   end_screen_anim #(
      .MAX_POS     (MAX_POS),
      .N_PLAYERS   (NP),
      .PEAK        (8'd5),
      .TICK_DIV    (2),
      .BLINK_TICKS (2),
      .BLINK_COUNT (4)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .enable            (enable),
      .clear             (clear),
      .pos_bus           (pos_bus),
      .led_number        (led_number),
      .i_red_intensity   (i_red),
      .i_green_intensity (i_green),
      .i_blue_intensity  (i_blue),
      .o_red_intensity   (o_red),
      .o_green_intensity (o_green),
      .o_blue_intensity  (o_blue),
      .winner_valid      (winner_valid),
      .winner_id         (winner_id)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic adv(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Render one LED and compare all three colour components
   task automatic led_chk(input string tag, input int led,
                          input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      led_number = PW'(led);
      #1;
      chk({tag, "_r"}, 32'(o_red),   32'(r));
      chk({tag, "_g"}, 32'(o_green), 32'(g));
      chk({tag, "_b"}, 32'(o_blue),  32'(b));
   endtask

   function automatic logic [NP*PW-1:0] at_finish(input int p);
      logic [NP*PW-1:0] v;
      v = '0;
      v[p*PW +: PW] = PW'(MAX_POS - 1);
      return v;
   endfunction

   initial begin
      rst_n      = 1'b0;
      enable     = 1'b0;
      clear      = 1'b0;
      pos_bus    = '0;
      led_number = '0;
      i_red      = 8'h33;
      i_green    = 8'h44;
      i_blue     = 8'h55;

      // 1: reset and pass-through
      #12;
      led_chk("rst_pass", 0, 8'h33, 8'h44, 8'h55);
      enable = 1'b1;
      led_chk("rst_en", 0, 8'h00, 8'h00, 8'h00);
      enable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      adv(2);
      chk("rst_valid", 32'(winner_valid), 32'd0);
      chk("rst_id",    32'(winner_id),    32'd0);
      led_chk("pass_0",   0,   8'h33, 8'h44, 8'h55);
      led_chk("pass_108", 108, 8'h33, 8'h44, 8'h55);
      led_chk("pass_120", 120, 8'h33, 8'h44, 8'h55);
      chk("pass_valid", 32'(winner_valid), 32'd0);

      // 2: player 2 wins, blue sweep
      pos_bus = at_finish(2);
      enable  = 1'b1;
      #1;
      chk("pre_latch_valid", 32'(winner_valid), 32'd0);
      adv(1);
      chk("p2_valid", 32'(winner_valid), 32'd1);
      chk("p2_id",    32'(winner_id),    32'd2);
      led_chk("p2_fill0", 0, 8'h00, 8'h00, 8'h00);
      pos_bus = at_finish(0);
      adv(20);
      chk("p2_id_kept", 32'(winner_id), 32'd2);
      led_chk("p2_led9",  9,  8'h00, 8'h00, 8'h05);
      led_chk("p2_led10", 10, 8'h00, 8'h00, 8'h00);

      // 5: enable dropped mid-sweep freezes the fill
      enable = 1'b0;
      adv(50);
      led_chk("dis_pass", 9, 8'h33, 8'h44, 8'h55);
      enable = 1'b1;
      led_chk("resume_led9",  9,  8'h00, 8'h00, 8'h05);
      led_chk("resume_led10", 10, 8'h00, 8'h00, 8'h00);
      adv(2);
      led_chk("resume_led10b", 10, 8'h00, 8'h00, 8'h05);
      led_chk("resume_led11",  11, 8'h00, 8'h00, 8'h00);

      // 3: simultaneous finishers, lowest index wins
      clear = 1'b1;
      adv(1);
      chk("clr_valid", 32'(winner_valid), 32'd0);
      led_chk("clr_idle", 0, 8'h00, 8'h00, 8'h00);
      clear   = 1'b0;
      pos_bus = at_finish(1) | at_finish(3);
      adv(1);
      chk("tie_valid", 32'(winner_valid), 32'd1);
      chk("tie_id",    32'(winner_id),    32'd1);
      adv(2);
      pos_bus = at_finish(0);
      led_chk("t_fill1_led0", 0, 8'h05, 8'h00, 8'h00);
      led_chk("t_fill1_led1", 1, 8'h00, 8'h00, 8'h00);
      chk("tie_id_kept", 32'(winner_id), 32'd1);

      // 4: full run timing (red)
      adv(217);
      led_chk("sweep_end_108", 108, 8'h05, 8'h00, 8'h00);
      led_chk("sweep_end_109", 109, 8'h00, 8'h00, 8'h00);
      adv(1);
      led_chk("blink_off1", 0, 8'h00, 8'h00, 8'h00);
      adv(4);
      led_chk("blink_on1",  0, 8'h05, 8'h00, 8'h00);
      adv(4);
      led_chk("blink_off2", 0, 8'h00, 8'h00, 8'h00);
      adv(4);
      led_chk("blink_on2",  0, 8'h05, 8'h00, 8'h00);
      adv(4);
      led_chk("hold_0",   0,   8'h05, 8'h00, 8'h00);
      adv(6);
      led_chk("hold_0b",  0,   8'h05, 8'h00, 8'h00);
      led_chk("hold_108", 108, 8'h05, 8'h00, 8'h00);
      led_chk("hold_109", 109, 8'h00, 8'h00, 8'h00);

      // 6: clear in HOLD, then async reset mid-blink
      clear = 1'b1;
      #1;
      chk("hold_valid_pre_clr", 32'(winner_valid), 32'd1);
      adv(1);
      chk("hold_clr_valid", 32'(winner_valid), 32'd0);
      led_chk("hold_clr_idle", 0, 8'h00, 8'h00, 8'h00);
      clear = 1'b0;
      adv(1);
      chk("g_valid", 32'(winner_valid), 32'd1);
      chk("g_id",    32'(winner_id),    32'd0);
      adv(224);
      led_chk("g_blink_on", 0, 8'h00, 8'h05, 8'h00);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(winner_valid), 32'd0);
      led_chk("arst_dark", 0, 8'h00, 8'h00, 8'h00);
      enable  = 1'b0;
      pos_bus = '0;
      adv(1);
      rst_n = 1'b1;
      adv(3);
      enable = 1'b1;
      adv(1);
      chk("post_rst_valid", 32'(winner_valid), 32'd0);
      led_chk("post_rst_idle", 5, 8'h00, 8'h00, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
